uart_tx_fifo: RTL

//  Parametrised UART transmitter, successor to the fixed-format UART block. Buffers bytes

---
 rtl/uart_tx_fifo.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter. Words enter a FIFO through a
// valid/ready handshake and are serialised on TXD as start, LSB-first data,
// optional parity and 1 or 2 stop bits.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          TXD,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL      = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;
  logic [AW:0]          count_next;
  logic                 push;
  logic                 pop;

  state_t               state;
  state_t               state_next;
  logic [BW-1:0]        baud;
  logic [BW-1:0]        baud_next;
  logic [3:0]           bit_idx;
  logic [3:0]           bit_next;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_next;
  logic                 par_bit;
  logic                 par_next;
  logic                 txd_r;
  logic                 txd_next;
  logic                 baud_end;

  assign push       = tx_valid & tx_ready;
  assign fifo_count = count;
  assign TXD        = txd_r;
  assign busy       = (state != ST_IDLE) | (count != '0);
  assign baud_end   = (baud == BAUD_LAST);

  // FIFO occupancy after this cycle's push/pop
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // FIFO pointers, count and registered ready (ready tracks count_next so it
  // is already correct in the cycle the count changes)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tx_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_next;
      tx_ready <= (count_next != FULL);
    end
  end

  // FIFO storage; contents need no reset because the pointers gate them
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // Frame sequencing; txd_next reflects the current state, so the line lags
  // the state register by one clock and each bit still lasts CLKS_PER_BIT
  always_comb begin
    state_next = state;
    baud_next  = baud;
    bit_next   = bit_idx;
    shreg_next = shreg;
    par_next   = par_bit;
    pop        = 1'b0;
    txd_next   = 1'b1;
    case (state)
      ST_IDLE: begin
        txd_next  = 1'b1;
        baud_next = '0;
        bit_next  = '0;
        if (count != '0) begin
          pop        = 1'b1;
          shreg_next = mem[rd_ptr];
          par_next   = (PARITY == 2) ? ^mem[rd_ptr] : ~^mem[rd_ptr];
          state_next = ST_START;
        end
      end
      ST_START: begin
        txd_next = 1'b0;
        if (baud_end) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = ST_DATA;
        end else begin
          baud_next = baud + 1'b1;
        end
      end
      ST_DATA: begin
        txd_next = shreg[0];
        if (baud_end) begin
          baud_next  = '0;
          shreg_next = shreg >> 1;
          if (bit_idx == DATA_LAST) begin
            bit_next   = '0;
            state_next = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_next = bit_idx + 4'd1;
          end
        end else begin
          baud_next = baud + 1'b1;
        end
      end
      ST_PARITY: begin
        txd_next = par_bit;
        if (baud_end) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = ST_STOP;
        end else begin
          baud_next = baud + 1'b1;
        end
      end
      ST_STOP: begin
        txd_next = 1'b1;
        if (baud_end) begin
          baud_next = '0;
          if (bit_idx == STOP_LAST) begin
            bit_next   = '0;
            state_next = ST_IDLE;
          end else begin
            bit_next = bit_idx + 4'd1;
          end
        end else begin
          baud_next = baud + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM and datapath registers; reset forces the line high immediately
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      txd_r   <= 1'b1;
    end else begin
      state   <= state_next;
      baud    <= baud_next;
      bit_idx <= bit_next;
      shreg   <= shreg_next;
      par_bit <= par_next;
      txd_r   <= txd_next;
    end
  end

endmodule
